sap_microseq: RTL and testbench

- Parametrised successor to the SAP-1 fixed-ring controller: a microsequencer that decodes `opcode` plus the current micro-step into the control signals for the SAP datapath.
- New behaviour over the fixed ring:
  - Early step reset: each instruction ends on its own last step.
  - Flag-conditional jumps, JC and JZ.
  - Latched halt.
  - Step enable input.
  - `instr_done` strobe.
- Sits between the instruction/flags registers and every bus-facing register in the CPU.

---
 rtl/sap_microseq.sv | 204 ++++++++++++++++++++
 tb/tb_sap_microseq.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sap_microseq.sv
// sap_microseq: SAP-1 microsequencer. Decodes the live opcode and micro-step
// into datapath control lines with zero latency. Each instruction ends on its
// own last step. JC/JZ jump on flags, HLT latches until reset, and step_en
// stalls the sequencer.
// Optional build macro SAP_SINGLE_STEP_EN adds a step_req input. With it, each
// rising edge of step_req permits exactly one step advance.
module sap_microseq #(
  parameter int unsigned OPCODE_W  = 4,
  parameter int unsigned FLAGS_W   = 4,
  parameter int unsigned MAX_STEPS = 6,
  parameter int unsigned CF_BIT    = 0,
  parameter int unsigned ZF_BIT    = 1,
  localparam int unsigned SW       = $clog2(MAX_STEPS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                step_en,
`ifdef SAP_SINGLE_STEP_EN
  input  logic                step_req,
`endif
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FLAGS_W-1:0]  flags,
  output logic                halt,
  output logic                reg_a_in,
  output logic                reg_a_out,
  output logic                reg_b_in,
  output logic                reg_b_out,
  output logic                alu_out,
  output logic                alu_sub,
  output logic                instr_in,
  output logic                instr_out,
  output logic                mar_in,
  output logic                ram_in,
  output logic                ram_out,
  output logic                reg_out,
  output logic                pc_inc,
  output logic                pc_out,
  output logic                pc_jmp,
  output logic [FLAGS_W-1:0]  reg_flags_in,
  output logic [SW-1:0]       step_out,
  output logic                instr_done
);

  typedef enum logic [3:0] {
    OP_NOP = 4'd0,
    OP_LDA = 4'd1,
    OP_ADD = 4'd2,
    OP_SUB = 4'd3,
    OP_STA = 4'd4,
    OP_LDI = 4'd5,
    OP_JMP = 4'd6,
    OP_JC  = 4'd7,
    OP_JZ  = 4'd8,
    OP_OUT = 4'd14,
    OP_HLT = 4'd15
  } op_e;

  logic [SW-1:0] t;
  logic          halted;
  logic [SW-1:0] last;
  logic          go;
  logic          at_t2, at_t3, at_t4;

  assign at_t2 = (t == SW'(2));
  assign at_t3 = (t == SW'(3));
  assign at_t4 = (t == SW'(4));

`ifdef SAP_SINGLE_STEP_EN
  logic req_q;
  logic rise_q;

  // Registered rising-edge detector; rise_q is a one-cycle permit to step
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      req_q  <= step_req;
      rise_q <= step_req & ~req_q;
    end
  end

  assign go = step_en & ~halted & rise_q;
`else
  assign go = step_en & ~halted;
`endif

  // Last micro-step of the current instruction
  always_comb begin
    last = SW'(2);
    case (opcode)
      OPCODE_W'(OP_LDA), OPCODE_W'(OP_STA): last = SW'(3);
      OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): last = SW'(4);
      default:                              last = SW'(2);
    endcase
  end

  // Step counter and halt latch; HLT parks at T2 instead of wrapping to T0
  always_ff @(posedge clk) begin
    if (rst) begin
      t      <= '0;
      halted <= 1'b0;
    end else if (go) begin
      if (opcode == OPCODE_W'(OP_HLT) && at_t2) begin
        halted <= 1'b1;
      end else if (t == last || t == SW'(MAX_STEPS - 1)) begin
        t <= '0;
      end else begin
        t <= t + SW'(1);
      end
    end
  end

  // Control decode from step, live opcode/flags and halt state
  always_comb begin
    {halt, reg_a_in, reg_a_out, reg_b_in, reg_b_out, alu_out, alu_sub,
     instr_in, instr_out, mar_in, ram_in, ram_out, reg_out, pc_inc,
     pc_out, pc_jmp} = '0;
    reg_flags_in = '0;
    if (halted) begin
      halt = 1'b1;
    end else if (t == SW'(0)) begin
      pc_out = 1'b1;
      mar_in = 1'b1;
    end else if (t == SW'(1)) begin
      ram_out  = 1'b1;
      instr_in = 1'b1;
      pc_inc   = 1'b1;
    end else begin
      case (opcode)
        OPCODE_W'(OP_LDA): begin
          if (at_t2) begin
            instr_out = 1'b1;
            mar_in    = 1'b1;
          end else if (at_t3) begin
            ram_out  = 1'b1;
            reg_a_in = 1'b1;
          end
        end
        OPCODE_W'(OP_ADD), OPCODE_W'(OP_SUB): begin
          if (at_t2) begin
            instr_out = 1'b1;
            mar_in    = 1'b1;
          end else if (at_t3) begin
            ram_out  = 1'b1;
            reg_b_in = 1'b1;
          end else if (at_t4) begin
            alu_out      = 1'b1;
            reg_a_in     = 1'b1;
            reg_flags_in = '1;
            alu_sub      = (opcode == OPCODE_W'(OP_SUB));
          end
        end
        OPCODE_W'(OP_STA): begin
          if (at_t2) begin
            instr_out = 1'b1;
            mar_in    = 1'b1;
          end else if (at_t3) begin
            reg_a_out = 1'b1;
            ram_in    = 1'b1;
          end
        end
        OPCODE_W'(OP_LDI): begin
          if (at_t2) begin
            instr_out = 1'b1;
            reg_a_in  = 1'b1;
          end
        end
        OPCODE_W'(OP_JMP): begin
          if (at_t2) begin
            instr_out = 1'b1;
            pc_jmp    = 1'b1;
          end
        end
        OPCODE_W'(OP_JC): begin
          if (at_t2 && flags[CF_BIT]) begin
            instr_out = 1'b1;
            pc_jmp    = 1'b1;
          end
        end
        OPCODE_W'(OP_JZ): begin
          if (at_t2 && flags[ZF_BIT]) begin
            instr_out = 1'b1;
            pc_jmp    = 1'b1;
          end
        end
        OPCODE_W'(OP_OUT): begin
          if (at_t2) begin
            reg_a_out = 1'b1;
            reg_out   = 1'b1;
          end
        end
        OPCODE_W'(OP_HLT): begin
          if (at_t2) halt = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign step_out   = t;
  assign instr_done = (t == last) && !halted;

endmodule

// File: tb/tb_sap_microseq.sv
// tb_sap_microseq: directed self-checking bench for sap_microseq.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_sap_microseq;

  logic       clk = 1'b0;
  logic       rst;
  logic       step_en;
  logic [3:0] opcode;
  logic [3:0] flags;
`ifdef SAP_SINGLE_STEP_EN
  logic       step_req;
`endif
  logic halt, reg_a_in, reg_a_out, reg_b_in, reg_b_out, alu_out, alu_sub;
  logic instr_in, instr_out, mar_in, ram_in, ram_out, reg_out, pc_inc;
  logic pc_out, pc_jmp, instr_done;
  logic [3:0] reg_flags_in;
  logic [2:0] step_out;
  logic [15:0] ctl;

  int unsigned checks = 0;
  int unsigned errors = 0;

  localparam logic [15:0] H  = 16'h8000, AI = 16'h4000, AO = 16'h2000,
                          BI = 16'h1000, BO = 16'h0800, EO = 16'h0400,
                          SU = 16'h0200, II = 16'h0100, IO = 16'h0080,
                          MI = 16'h0040, RI = 16'h0020, RO = 16'h0010,
                          OI = 16'h0008, CE = 16'h0004, CO = 16'h0002,
                          J  = 16'h0001, NONE = 16'h0000;

  always #5 clk = ~clk;

  sap_microseq #(
    .OPCODE_W (4),
    .FLAGS_W  (4),
    .MAX_STEPS(6),
    .CF_BIT   (0),
    .ZF_BIT   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .step_en     (step_en),
`ifdef SAP_SINGLE_STEP_EN
    .step_req    (step_req),
`endif
    .opcode      (opcode),
    .flags       (flags),
    .halt        (halt),
    .reg_a_in    (reg_a_in),
    .reg_a_out   (reg_a_out),
    .reg_b_in    (reg_b_in),
    .reg_b_out   (reg_b_out),
    .alu_out     (alu_out),
    .alu_sub     (alu_sub),
    .instr_in    (instr_in),
    .instr_out   (instr_out),
    .mar_in      (mar_in),
    .ram_in      (ram_in),
    .ram_out     (ram_out),
    .reg_out     (reg_out),
    .pc_inc      (pc_inc),
    .pc_out      (pc_out),
    .pc_jmp      (pc_jmp),
    .reg_flags_in(reg_flags_in),
    .step_out    (step_out),
    .instr_done  (instr_done)
  );

  assign ctl = {halt, reg_a_in, reg_a_out, reg_b_in, reg_b_out, alu_out, alu_sub,
                instr_in, instr_out, mar_in, ram_in, ram_out, reg_out, pc_inc,
                pc_out, pc_jmp};

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  task automatic step_chk(input string name, input logic [2:0] et, input logic [15:0] ectl,
                          input logic [3:0] eflg, input logic edone);
    chk({name, ".step"}, 32'(step_out), 32'(et));
    chk({name, ".ctl"},  32'(ctl),      32'(ectl));
    chk({name, ".flg"},  32'(reg_flags_in), 32'(eflg));
    chk({name, ".done"}, 32'(instr_done),   32'(edone));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Checks the common fetch steps T0 and T1 and leaves the DUT at T2
  task automatic fetch(input string name);
    step_chk({name, ".t0"}, 3'd0, CO | MI, 4'h0, 1'b0);
    tick();
    step_chk({name, ".t1"}, 3'd1, RO | II | CE, 4'h0, 1'b0);
    tick();
  endtask

  initial begin
    rst = 1'b1;
    step_en = 1'b1;
    opcode = 4'd5;
    flags = 4'h0;
`ifdef SAP_SINGLE_STEP_EN
    step_req = 1'b0;
`endif
    tick();
    tick();
    step_chk("reset", 3'd0, CO | MI, 4'h0, 1'b0);
    rst = 1'b0;

`ifdef SAP_SINGLE_STEP_EN
    opcode = 4'd2;
    repeat (5) tick();
    chk("ss.frozen", 32'(step_out), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      repeat (3) tick();
    end
    chk("ss.three", 32'(step_out), 32'd3);
    step_req = 1'b1;
    repeat (4) tick();
    chk("ss.held_high", 32'(step_out), 32'd4);
    step_req = 1'b0;
    repeat (3) tick();
    chk("ss.no_rise", 32'(step_out), 32'd4);
`else
    // LDI: T sequence 0,1,2,0,1,2
    fetch("ldi");
    step_chk("ldi.t2", 3'd2, IO | AI, 4'h0, 1'b1);
    tick();
    fetch("ldi_b");
    step_chk("ldi_b.t2", 3'd2, IO | AI, 4'h0, 1'b1);
    tick();

    // ADD: runs to T4
    opcode = 4'd2;
    fetch("add");
    step_chk("add.t2", 3'd2, IO | MI, 4'h0, 1'b0);
    tick();
    step_chk("add.t3", 3'd3, RO | BI, 4'h0, 1'b0);
    tick();
    step_chk("add.t4", 3'd4, EO | AI, 4'hF, 1'b1);
    tick();

    // SUB: adds alu_sub at T4
    opcode = 4'd3;
    fetch("sub");
    step_chk("sub.t2", 3'd2, IO | MI, 4'h0, 1'b0);
    tick();
    step_chk("sub.t3", 3'd3, RO | BI, 4'h0, 1'b0);
    tick();
    step_chk("sub.t4", 3'd4, EO | AI | SU, 4'hF, 1'b1);
    tick();

    // LDA, STA end on T3
    opcode = 4'd1;
    fetch("lda");
    step_chk("lda.t2", 3'd2, IO | MI, 4'h0, 1'b0);
    tick();
    step_chk("lda.t3", 3'd3, RO | AI, 4'h0, 1'b1);
    tick();
    opcode = 4'd4;
    fetch("sta");
    step_chk("sta.t2", 3'd2, IO | MI, 4'h0, 1'b0);
    tick();
    step_chk("sta.t3", 3'd3, AO | RI, 4'h0, 1'b1);
    tick();

    // JMP, conditional jumps, OUT, NOP and an unlisted opcode
    opcode = 4'd6;
    fetch("jmp");
    step_chk("jmp.t2", 3'd2, IO | J, 4'h0, 1'b1);
    tick();
    opcode = 4'd7; flags = 4'b0001;
    fetch("jc_taken");
    step_chk("jc_taken.t2", 3'd2, IO | J, 4'h0, 1'b1);
    tick();
    flags = 4'b0000;
    fetch("jc_not");
    step_chk("jc_not.t2", 3'd2, NONE, 4'h0, 1'b1);
    tick();
    opcode = 4'd8; flags = 4'b0010;
    fetch("jz_taken");
    step_chk("jz_taken.t2", 3'd2, IO | J, 4'h0, 1'b1);
    tick();
    flags = 4'b0001;
    fetch("jz_not");
    step_chk("jz_not.t2", 3'd2, NONE, 4'h0, 1'b1);
    tick();
    flags = 4'h0;
    opcode = 4'd14;
    fetch("out");
    step_chk("out.t2", 3'd2, AO | OI, 4'h0, 1'b1);
    tick();
    opcode = 4'd0;
    fetch("nop");
    step_chk("nop.t2", 3'd2, NONE, 4'h0, 1'b1);
    tick();
    opcode = 4'd10;
    fetch("op10");
    step_chk("op10.t2", 3'd2, NONE, 4'h0, 1'b1);
    tick();

    // ADD stalled at T3 for three cycles
    opcode = 4'd2;
    fetch("stall");
    tick();
    step_chk("stall.t3", 3'd3, RO | BI, 4'h0, 1'b0);
    step_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      step_chk("stall.hold", 3'd3, RO | BI, 4'h0, 1'b0);
    end
    step_en = 1'b1;
    tick();
    step_chk("stall.t4", 3'd4, EO | AI, 4'hF, 1'b1);
    tick();

    // Reset in the middle of ADD
    fetch("midrst");
    tick();
    step_chk("midrst.t3", 3'd3, RO | BI, 4'h0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    step_chk("midrst.after", 3'd0, CO | MI, 4'h0, 1'b0);

    // HLT latches, ignores opcode changes, and only reset clears it
    opcode = 4'd15;
    fetch("hlt");
    step_chk("hlt.t2", 3'd2, H, 4'h0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 10) opcode = 4'd2;
      step_chk("hlt.held", 3'd2, H, 4'h0, 1'b0);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    step_chk("hlt.rst", 3'd0, CO | MI, 4'h0, 1'b0);
    tick();
    step_chk("hlt.resume", 3'd1, RO | II | CE, 4'h0, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
